rr_arbiter4: RTL and testbench

//  Round-robin arbiter sharing one 2-to-4 decoded select resource among 4 requesters.

---
 rtl/rr_arbiter4.sv | 133 +++++++++++++
 tb/tb_rr_arbiter4.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter granting one of four requesters a shared 2-to-4 decoded resource.
// Define ARB_TIMEOUT_EN to revoke a grant held for MAX_HOLD cycles and pulse timeout.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic [1:0] dec_din,
  output logic       dec_en,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] cand;
  logic [1:0] pick_idx;
  logic       pick_vld;
  logic       owner_req;

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_param_check
    $error("rr_arbiter4: MAX_HOLD must be 2..255 and below 2**CNT_W");
  end

  // Scan starts just after the last winner, so the previous owner ranks lowest.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last;
    cand     = last;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign owner_req = req[gnt_idx];
  assign dec_din   = {gnt_idx[0], gnt_idx[1]};
  assign dec_en    = gnt_vld;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 2'd3;
      gnt      <= 4'b0000;
      gnt_idx  <= 2'd0;
      gnt_vld  <= 1'b0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= GRANT;
            last     <= pick_idx;
            gnt      <= 4'b0001 << pick_idx;
            gnt_idx  <= pick_idx;
            gnt_vld  <= 1'b1;
            hold_cnt <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (!owner_req) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            gnt_idx <= 2'd0;
            gnt_vld <= 1'b0;
          end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
            // Forced revoke; last keeps the owner so others are served first.
            state   <= IDLE;
            gnt     <= 4'b0000;
            gnt_idx <= 2'd0;
            gnt_vld <= 1'b0;
            timeout <= 1'b1;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 2'd3;
      gnt     <= 4'b0000;
      gnt_idx <= 2'd0;
      gnt_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state   <= GRANT;
            last    <= pick_idx;
            gnt     <= 4'b0001 << pick_idx;
            gnt_idx <= pick_idx;
            gnt_vld <= 1'b1;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            gnt_idx <= 2'd0;
            gnt_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed scoreboard bench for rr_arbiter4; expectations are queued per driven cycle
// and checked one cycle later, including the decoder output implied by dec_din/dec_en.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic [1:0] dec_din;
  logic       dec_en;
  logic       timeout;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] gnt;
    logic       to;
  } exp_t;

  exp_t expQ[$];
  int   compareCount = 0;
  int   failCount    = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .dec_din (dec_din),
    .dec_en  (dec_en),
    .timeout (timeout)
  );

  function automatic logic [1:0] idxOf(input logic [3:0] oneHot);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (oneHot[i]) idx = 2'(i);
    return idx;
  endfunction

  task automatic checkField(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    compareCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq,
                               input logic [3:0] expGnt, input logic expTo);
    exp_t e;
    rst   = r;
    req   = rq;
    e.gnt = expGnt;
    e.to  = expTo;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t       e;
    logic [1:0] ei;
    logic [3:0] dout;
    compareCount++;
    assert (expQ.size() != 0) else begin
      failCount++;
      $error("[TB] FAIL %s.queue: observed empty expected entry", tag);
    end
    if (expQ.size() != 0) begin
      e    = expQ.pop_front();
      ei   = idxOf(e.gnt);
      dout = dec_en ? (4'b0001 << {dec_din[0], dec_din[1]}) : 4'b0000;
      checkField({tag, ".gnt"},     gnt,                 e.gnt);
      checkField({tag, ".gnt_idx"}, {2'b00, gnt_idx},    {2'b00, ei});
      checkField({tag, ".gnt_vld"}, {3'b000, gnt_vld},   {3'b000, |e.gnt});
      checkField({tag, ".dec_din"}, {2'b00, dec_din},    {2'b00, ei[0], ei[1]});
      checkField({tag, ".dec_en"},  {3'b000, dec_en},    {3'b000, |e.gnt});
      checkField({tag, ".timeout"}, {3'b000, timeout},   {3'b000, e.to});
      checkField({tag, ".dout"},    dout,                e.gnt);
    end
  endtask

  task automatic cycle(input string tag, input logic r, input logic [3:0] rq,
                       input logic [3:0] expGnt, input logic expTo);
    applyStimulus(r, rq, expGnt, expTo);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'h0;

    $display("[TB] reset with all requests high");
    cycle("rst0", 1, 4'hF, 4'b0000, 0);
    cycle("rst1", 1, 4'hF, 4'b0000, 0);
    cycle("first", 0, 4'hF, 4'b0001, 0);

    $display("[TB] fairness with all requesting");
    cycle("f0a", 0, 4'hF, 4'b0001, 0);
    cycle("f0b", 0, 4'hF, 4'b0001, 0);
    cycle("f0d", 0, 4'hE, 4'b0000, 0);
    cycle("f1a", 0, 4'hF, 4'b0010, 0);
    cycle("f1b", 0, 4'hF, 4'b0010, 0);
    cycle("f1c", 0, 4'hF, 4'b0010, 0);
    cycle("f1d", 0, 4'hD, 4'b0000, 0);
    cycle("f2a", 0, 4'hF, 4'b0100, 0);
    cycle("f2b", 0, 4'hF, 4'b0100, 0);
    cycle("f2c", 0, 4'hF, 4'b0100, 0);
    cycle("f2d", 0, 4'hB, 4'b0000, 0);
    cycle("f3a", 0, 4'hF, 4'b1000, 0);
    cycle("f3b", 0, 4'hF, 4'b1000, 0);
    cycle("f3c", 0, 4'hF, 4'b1000, 0);
    cycle("f3d", 0, 4'h7, 4'b0000, 0);
    cycle("f0w", 0, 4'hF, 4'b0001, 0);
    cycle("fend", 0, 4'h0, 4'b0000, 0);

    $display("[TB] single request latency");
    cycle("latR", 1, 4'h0, 4'b0000, 0);
    cycle("lat0", 0, 4'h4, 4'b0100, 0);
    cycle("lat1", 0, 4'h4, 4'b0100, 0);
    cycle("latD", 0, 4'h0, 4'b0000, 0);

    $display("[TB] wrap and skip");
    cycle("wrR", 1, 4'h0, 4'b0000, 0);
    cycle("wr1", 0, 4'hA, 4'b0010, 0);
    cycle("wr1d", 0, 4'h8, 4'b0000, 0);
    cycle("wr3", 0, 4'hA, 4'b1000, 0);
    cycle("wr3d", 0, 4'h2, 4'b0000, 0);
    cycle("wr1b", 0, 4'hA, 4'b0010, 0);
    cycle("simD", 0, 4'h1, 4'b0000, 0);
    cycle("sim0", 0, 4'h1, 4'b0001, 0);
    cycle("wend", 0, 4'h0, 4'b0000, 0);

    $display("[TB] reset mid-grant");
    cycle("mgR", 1, 4'h0, 4'b0000, 0);
    cycle("mg2", 0, 4'h4, 4'b0100, 0);
    cycle("mgX", 1, 4'h4, 4'b0000, 0);
    cycle("mg0", 0, 4'h5, 4'b0001, 0);

    $display("[TB] long hold with competing request");
    cycle("toR", 1, 4'h0, 4'b0000, 0);
    cycle("to0", 0, 4'h3, 4'b0001, 0);
    cycle("to1", 0, 4'h3, 4'b0001, 0);
    cycle("to2", 0, 4'h3, 4'b0001, 0);
    cycle("to3", 0, 4'h3, 4'b0001, 0);
    cycle("to4", 0, 4'h3, TO_EN ? 4'b0000 : 4'b0001, TO_EN);
    cycle("to5", 0, 4'h3, TO_EN ? 4'b0010 : 4'b0001, 0);
    cycle("to6", 0, 4'h3, TO_EN ? 4'b0010 : 4'b0001, 0);
    cycle("to7", 0, 4'h3, TO_EN ? 4'b0010 : 4'b0001, 0);
    cycle("to8", 0, 4'h3, TO_EN ? 4'b0010 : 4'b0001, 0);
    cycle("to9", 0, 4'h3, TO_EN ? 4'b0000 : 4'b0001, TO_EN);
    cycle("to10", 0, 4'h3, 4'b0001, 0);
    cycle("toD", 0, 4'h0, 4'b0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
